// File: rtl/local_packet_injector.sv
// Local-port packet injector: serialises HEADER, SIZE and buffered payload flits
// into one router LOCAL input port under the router's credit flow control.
module local_packet_injector #(
    parameter int TAM_FLIT   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TAM_FLIT-1:0] req_target,
    input  logic [TAM_FLIT-1:0] req_size,
    input  logic                pl_wr,
    input  logic [TAM_FLIT-1:0] pl_data,
    output logic                pl_full,
    output logic [FIFO_AW:0]    pl_count,
    output logic                clock_tx,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                pkt_sent,
    output logic                ovf_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD
    } state_t;

    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic [TAM_FLIT-1:0] target_q, target_d;
    logic [TAM_FLIT-1:0] size_q, size_d;
    logic [TAM_FLIT-1:0] rem_q, rem_d;
    logic                pkt_sent_q, pkt_sent_d;
    logic                live_q;

    logic [TAM_FLIT-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [TAM_FLIT-1:0] fifo_head;

    assign clock_tx = clock;

    // A push into a full FIFO is dropped even when a pop happens on the same edge.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign push       = pl_wr && !fifo_full;
    assign fifo_head  = mem_q[rd_ptr_q];

    assign wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    assign count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    assign ovf_d    = ovf_q | (pl_wr & fifo_full);

    assign pl_full  = fifo_full;
    assign pl_count = count_q;
    assign pkt_sent = pkt_sent_q;
    assign ovf_err  = ovf_q;

    // NOTE: payload storage has no reset; a slot is only ever read after it was written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pl_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: registers update with non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            size_q     <= '0;
            rem_q      <= '0;
            pkt_sent_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            size_q     <= size_d;
            rem_q      <= rem_d;
            pkt_sent_q <= pkt_sent_d;
            live_q     <= 1'b1;
        end
    end

    // tx/data_out come only from registered state and the FIFO head, never from credit_i.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        target_d   = target_q;
        size_d     = size_q;
        rem_d      = rem_q;
        pkt_sent_d = 1'b0;
        req_ready  = 1'b0;
        tx         = 1'b0;
        data_out   = '0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = live_q;
                if (req_valid && live_q) begin
                    target_d = req_target;
                    size_d   = req_size;
                    state_d  = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx       = 1'b1;
                data_out = target_q;
                if (credit_i) begin
                    state_d = ST_SIZE;
                end
            end
            ST_SIZE: begin
                tx       = 1'b1;
                data_out = size_q;
                if (credit_i) begin
                    if (size_q == '0) begin
                        state_d    = ST_IDLE;
                        pkt_sent_d = 1'b1;
                    end else begin
                        rem_d   = size_q;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                tx       = !fifo_empty;
                data_out = fifo_empty ? '0 : fifo_head;
                if (!fifo_empty && credit_i) begin
                    pop   = 1'b1;
                    rem_d = rem_q - TAM_FLIT'(1);
                    if (rem_q == TAM_FLIT'(1)) begin
                        state_d    = ST_IDLE;
                        pkt_sent_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
